beat_sequencer: RTL and testbench

//   Tempo controller for the 8-bit beat counter (enable/clock/clear_b T-flip-flop chain).

---
 rtl/beat_sequencer.sv | 97 +++++++++
 tb/tb_beat_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/beat_sequencer.sv
// beat_sequencer: tempo controller that paces the 8-bit beat counter through one song run
// Ports:
//   clock, reset_n         system clock, asynchronous active-low reset
//   start, pause, stop     game FSM commands, priority stop > start > pause
//   period                 clock cycles per beat (0 behaves as 1), sampled live
//   last_beat              final beat index of the song, sampled live
//   cnt_q                  current beat counter value
//   cnt_enable, beat_tick  one-cycle pulse per beat
//   cnt_clear_b            active-low counter clear
//   running, done, state   run status (IDLE=0, RUN=1, PAUSE=2, DONE=3)
module beat_sequencer #(
  parameter int DIV_WIDTH = 26
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 stop,
  input  logic [DIV_WIDTH-1:0] period,
  input  logic [7:0]           last_beat,
  input  logic [7:0]           cnt_q,
  output logic                 cnt_enable,
  output logic                 cnt_clear_b,
  output logic                 beat_tick,
  output logic                 running,
  output logic                 done,
  output logic [1:0]           state
);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_t;
  state_t st, st_n;
  logic [DIV_WIDTH-1:0] div, div_n, p_m1;
  logic [8:0] beat_pos;
  logic pulse_n, clr_n, hit;
  assign p_m1 = (period == '0) ? '0 : period - 1'b1;
  assign hit = div >= p_m1;
  // Beats already issued: a pulse still in flight has not reached cnt_q yet,
  // and a counter under clear counts as zero.
  assign beat_pos = cnt_clear_b ? {1'b0, cnt_q} + {8'd0, cnt_enable} : 9'd0;
  assign state = st;
  always_comb begin
    st_n = st;
    div_n = div;
    pulse_n = 1'b0;
    clr_n = cnt_clear_b;
    if (stop) begin
      st_n = ST_IDLE;
      div_n = '0;
      clr_n = 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          div_n = '0;
          clr_n = start;
          st_n = start ? ST_RUN : ST_IDLE;
        end
        ST_DONE: begin
          st_n = start ? ST_RUN : ST_DONE;
          div_n = start ? '0 : div;
          clr_n = !start;
        end
        ST_PAUSE: begin
          clr_n = 1'b1;
          st_n = start ? ST_RUN : ST_PAUSE;
        end
        ST_RUN: begin
          clr_n = 1'b1;
          if (pause && !start) st_n = ST_PAUSE;
          else if (hit) begin
            div_n = '0;
            pulse_n = beat_pos != {1'b0, last_beat};
            st_n = pulse_n ? ST_RUN : ST_DONE;
          end else div_n = div + 1'b1;
        end
        default: st_n = ST_IDLE;
      endcase
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st <= ST_IDLE;
      div <= '0;
      cnt_enable <= 1'b0;
      beat_tick <= 1'b0;
      cnt_clear_b <= 1'b0;
      running <= 1'b0;
      done <= 1'b0;
    end else begin
      st <= st_n;
      div <= div_n;
      cnt_enable <= pulse_n;
      beat_tick <= pulse_n;
      cnt_clear_b <= clr_n;
      running <= st_n == ST_RUN;
      done <= st_n == ST_DONE;
    end
  end
endmodule

// File: tb/tb_beat_sequencer.sv
// tb_beat_sequencer: scoreboard bench for beat_sequencer with a beat counter model
module tb_beat_sequencer;
  logic clock = 0, reset_n = 0, start = 0, pause = 0, stop = 0;
  logic [25:0] period = 26'd4;
  logic [7:0] last_beat = 8'd3, cnt_q = 8'd0;
  logic cnt_enable, cnt_clear_b, beat_tick, running, done;
  logic [1:0] state;
  typedef struct packed {logic [1:0] st; logic en, tk, clr, run, dn;} exp_t;
  exp_t q[$];
  exp_t e;
  int total = 0, bad = 0;
  int m_st = 0, m_beats = 0;
  longint m_elapsed = 0;
  bit m_clr = 0;
  beat_sequencer #(.DIV_WIDTH(26)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .pause(pause), .stop(stop),
    .period(period), .last_beat(last_beat), .cnt_q(cnt_q), .cnt_enable(cnt_enable),
    .cnt_clear_b(cnt_clear_b), .beat_tick(beat_tick), .running(running), .done(done),
    .state(state)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cnt_q <= !cnt_clear_b ? 8'd0 : cnt_enable ? cnt_q + 8'd1 : cnt_q;
  always @(posedge clock) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if ({state, cnt_enable, beat_tick, cnt_clear_b, running, done} !== e) begin
        bad++;
        $display("FAIL cycle t=%0t: state,en,tick,clr_b,run,done got %b want %b", $time,
                 {state, cnt_enable, beat_tick, cnt_clear_b, running, done}, e);
      end
    end
  end
  task automatic chk(input string n, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, got, want);
    end
  endtask
  // Reference: m_elapsed counts RUN cycles spent in the current beat, m_beats the
  // pulses issued since the counter was last cleared.
  task automatic model_step();
    longint p = (period == 0) ? 1 : longint'(period);
    bit pl = 0;
    if (stop) begin
      m_st = 0; m_elapsed = 0; m_clr = 0;
    end else if (m_st == 0) begin
      m_elapsed = 0; m_clr = start;
      if (start) begin m_st = 1; m_beats = 0; end
    end else if (m_st == 3) begin
      if (start) begin m_st = 1; m_elapsed = 0; m_clr = 0; m_beats = 0; end
      else m_clr = 1;
    end else if (m_st == 2) begin
      m_clr = 1;
      if (start) m_st = 1;
    end else begin
      m_clr = 1;
      if (pause && !start) m_st = 2;
      else if (m_elapsed + 1 >= p) begin
        m_elapsed = 0;
        if (m_beats != int'(last_beat)) begin pl = 1; m_beats++; end
        else m_st = 3;
      end else m_elapsed++;
    end
    e.st = 2'(m_st); e.en = pl; e.tk = pl; e.clr = m_clr;
    e.run = m_st == 1; e.dn = m_st == 3;
    q.push_back(e);
  endtask
  task automatic cyc(input bit s, input bit pa, input bit sp, input logic [25:0] per,
                     input logic [7:0] lb);
    @(negedge clock);
    start = s; pause = pa; stop = sp; period = per; last_beat = lb;
    model_step();
  endtask
  task automatic idle(input int n, input logic [25:0] per, input logic [7:0] lb);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, per, lb);
  endtask
  task automatic sample();
    @(posedge clock);
    #1;
  endtask
  logic [25:0] rp;
  logic [7:0] rl;
  initial begin
    repeat (3) @(negedge clock);
    reset_n = 1;
    idle(2, 4, 3);
    cyc(1, 0, 0, 3, 50);
    idle(6, 3, 50);
    @(posedge clock);
    #2;
    reset_n = 0;
    q.delete();
    m_st = 0; m_elapsed = 0; m_clr = 0; m_beats = 0;
    #1;
    chk("async_reset_state", state, 0);
    chk("async_reset_clear_b", cnt_clear_b, 0);
    chk("async_reset_enable", cnt_enable, 0);
    repeat (2) @(negedge clock);
    reset_n = 1;
    idle(10, 3, 50);
    cyc(1, 0, 0, 4, 3);
    idle(17, 4, 3);
    sample();
    chk("song_done", done, 1);
    chk("song_state", state, 3);
    chk("song_cnt_q", cnt_q, 3);
    cyc(1, 0, 0, 4, 3);
    sample();
    chk("restart_clear_b", cnt_clear_b, 0);
    chk("restart_state", state, 1);
    cyc(0, 0, 0, 4, 3);
    sample();
    chk("restart_cnt_q", cnt_q, 0);
    chk("restart_clear_b_release", cnt_clear_b, 1);
    idle(6, 4, 3);
    cyc(0, 0, 1, 0, 5);
    cyc(1, 0, 0, 0, 5);
    idle(10, 0, 5);
    sample();
    chk("p0_state", state, 3);
    chk("p0_cnt_q", cnt_q, 5);
    cyc(1, 0, 0, 8, 10);
    idle(7, 8, 10);
    cyc(0, 1, 0, 8, 10);
    sample();
    chk("pause_state", state, 2);
    chk("pause_no_pulse", cnt_enable, 0);
    cyc(1, 0, 0, 8, 10);
    cyc(0, 0, 0, 8, 10);
    sample();
    chk("resume_pulse", cnt_enable, 1);
    idle(5, 4, 10);
    cyc(1, 0, 1, 4, 10);
    sample();
    chk("stop_state", state, 0);
    chk("stop_clear_b", cnt_clear_b, 0);
    cyc(0, 0, 0, 4, 10);
    sample();
    chk("stop_cnt_q", cnt_q, 0);
    cyc(1, 0, 0, 1, 255);
    idle(270, 1, 255);
    sample();
    chk("lb255_cnt_q", cnt_q, 255);
    chk("lb255_done", done, 1);
    rp = 26'd3;
    rl = 8'd4;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) rp = 26'($urandom_range(0, 6));
      if ($urandom_range(0, 39) == 0) rl = 8'($urandom_range(0, 5));
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0,
          rp, rl);
    end
    @(posedge clock);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
